// File: rtl/tuple_operand_skid_buffer_if.sv
// Handshake bundle for the tuple operand skid buffer: upstream I0/I1 pair,
// downstream O0/O1 pair and the delivered-pair counter.
interface tuple_operand_skid_buffer_if #(
  parameter int FIELD_W = 1,
  parameter int CNT_W   = 8
);
  logic [FIELD_W-1:0] I0_x;
  logic [FIELD_W-1:0] I0_y;
  logic [FIELD_W-1:0] I1_x;
  logic [FIELD_W-1:0] I1_y;
  logic               in_valid;
  logic               in_ready;
  logic [FIELD_W-1:0] O0_x;
  logic [FIELD_W-1:0] O0_y;
  logic [FIELD_W-1:0] O1_x;
  logic [FIELD_W-1:0] O1_y;
  logic               out_valid;
  logic               out_ready;
  logic [CNT_W-1:0]   XFER_COUNT;

  modport master (
    output I0_x, I0_y, I1_x, I1_y, in_valid, out_ready,
    input  in_ready, O0_x, O0_y, O1_x, O1_y, out_valid, XFER_COUNT
  );

  modport slave (
    input  I0_x, I0_y, I1_x, I1_y, in_valid, out_ready,
    output in_ready, O0_x, O0_y, O1_x, O1_y, out_valid, XFER_COUNT
  );
endinterface

// File: rtl/tuple_operand_skid_buffer.sv
// Two-entry skid buffer feeding the tuple And2 operands; in_ready and all
// outputs come straight from flops, and delivered pairs are counted.
module tuple_operand_skid_buffer #(
  parameter int FIELD_W = 1,
  parameter int CNT_W   = 8
) (
  input logic                      CLK,
  input logic                      ASYNCRESETN,
  tuple_operand_skid_buffer_if.slave bus
);
  localparam int PAIR_W = 4 * FIELD_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PAIR_W-1:0] m_q, m_d;
  logic [PAIR_W-1:0] s_q, s_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAIR_W-1:0] in_pair_s;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_pair_s  = {bus.I0_x, bus.I0_y, bus.I1_x, bus.I1_y};
  assign in_fire_s  = bus.in_valid & in_ready_q;
  assign out_fire_s = out_valid_q & bus.out_ready;

  // Next-state, storage steering and counter update
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire_s) begin
          state_d = ST_ONE;
          m_d     = in_pair_s;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (in_fire_s && !out_fire_s) begin
          state_d = ST_FULL;
          s_d     = in_pair_s;
        end else if (in_fire_s && out_fire_s) begin
          m_d     = in_pair_s;
        end else if (out_fire_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so the only event is draining M and promoting S
        if (out_fire_s) begin
          state_d = ST_ONE;
          m_d     = s_q;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);

    if (out_fire_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, data and status registers
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= ST_EMPTY;
      m_q         <= {PAIR_W{1'b0}};
      s_q         <= {PAIR_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.XFER_COUNT = cnt_q;
  assign bus.O0_x       = m_q[4*FIELD_W-1 -: FIELD_W];
  assign bus.O0_y       = m_q[3*FIELD_W-1 -: FIELD_W];
  assign bus.O1_x       = m_q[2*FIELD_W-1 -: FIELD_W];
  assign bus.O1_y       = m_q[1*FIELD_W-1 -: FIELD_W];
endmodule

// File: tb/tb_tuple_operand_skid_buffer.sv
// Directed bench for tuple_operand_skid_buffer: reset, single pair, streaming,
// backpressure, counter wrap on a 2-bit instance, and reset while full.
module tb_tuple_operand_skid_buffer;
  logic CLK;
  logic ASYNCRESETN;
  int   n_vec;
  int   n_miss;

  tuple_operand_skid_buffer_if #(.FIELD_W(1), .CNT_W(8)) tif ();
  tuple_operand_skid_buffer_if #(.FIELD_W(1), .CNT_W(2)) wif ();

  tuple_operand_skid_buffer #(.FIELD_W(1), .CNT_W(8)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(tif.slave)
  );

  tuple_operand_skid_buffer #(.FIELD_W(1), .CNT_W(2)) dut_wrap (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(wif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] o_pair();
    return {tif.O0_x, tif.O0_y, tif.O1_x, tif.O1_y};
  endfunction

  task automatic drive(input logic v, input logic [3:0] p);
    tif.in_valid = v;
    {tif.I0_x, tif.I0_y, tif.I1_x, tif.I1_y} = p;
  endtask

  task automatic drive_w(input logic v, input logic [3:0] p);
    wif.in_valid = v;
    {wif.I0_x, wif.I0_y, wif.I1_x, wif.I1_y} = p;
  endtask

  task automatic do_reset();
    ASYNCRESETN = 1'b0;
    step();
    ASYNCRESETN = 1'b1;
    step();
  endtask

  logic [3:0] pat [8];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    pat[0] = 4'h1; pat[1] = 4'hE; pat[2] = 4'h5; pat[3] = 4'hA;
    pat[4] = 4'h3; pat[5] = 4'hC; pat[6] = 4'h9; pat[7] = 4'h6;

    ASYNCRESETN   = 1'b0;
    drive(1'b0, 4'h0);
    drive_w(1'b0, 4'h0);
    tif.out_ready = 1'b1;
    wif.out_ready = 1'b1;
    step();
    step();
    ASYNCRESETN = 1'b1;
    step();

    // 1: asynchronous reset mid-cycle with a pair held at the output
    tif.out_ready = 1'b0;
    drive(1'b1, 4'hF);
    step();
    drive(1'b0, 4'h0);
    chk("pre_rst_valid", 32'(tif.out_valid), 32'd1);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("rst_out_valid", 32'(tif.out_valid), 32'd0);
    chk("rst_in_ready", 32'(tif.in_ready), 32'd1);
    chk("rst_o_pair", 32'(o_pair()), 32'd0);
    chk("rst_count", 32'(tif.XFER_COUNT), 32'd0);
    step();
    ASYNCRESETN = 1'b1;
    step();

    // 2: single pair I0=(1,0) I1=(1,1)
    tif.out_ready = 1'b1;
    drive(1'b1, 4'b1011);
    step();
    drive(1'b0, 4'h0);
    chk("single_valid", 32'(tif.out_valid), 32'd1);
    chk("single_o_pair", 32'(o_pair()), 32'hB);
    chk("single_and2", 32'({tif.O0_x & tif.O1_x, tif.O0_y & tif.O1_y}), 32'b10);
    step();
    chk("single_count", 32'(tif.XFER_COUNT), 32'd1);
    chk("single_drained", 32'(tif.out_valid), 32'd0);

    // 3: eight pairs back-to-back
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, pat[i]);
      step();
      chk($sformatf("stream_ready_%0d", i), 32'(tif.in_ready), 32'd1);
      chk($sformatf("stream_data_%0d", i), 32'({tif.out_valid, o_pair()}), 32'({1'b1, pat[i]}));
    end
    drive(1'b0, 4'h0);
    step();
    chk("stream_count", 32'(tif.XFER_COUNT), 32'd8);
    chk("stream_empty", 32'(tif.out_valid), 32'd0);

    // 4: backpressure with A=0x3, B=0xC, C=0x6 held while full
    do_reset();
    tif.out_ready = 1'b0;
    drive(1'b1, 4'h3);
    step();
    chk("bp_a_ready", 32'(tif.in_ready), 32'd1);
    drive(1'b1, 4'hC);
    step();
    chk("bp_full_ready", 32'(tif.in_ready), 32'd0);
    chk("bp_hold_a", 32'({tif.out_valid, o_pair()}), 32'h13);
    drive(1'b1, 4'h6);
    step();
    step();
    chk("bp_c_ignored", 32'({tif.in_ready, o_pair()}), 32'h03);
    tif.out_ready = 1'b1;
    step();
    chk("bp_out_b", 32'({tif.out_valid, o_pair()}), 32'h1C);
    chk("bp_ready_back", 32'(tif.in_ready), 32'd1);
    step();
    drive(1'b0, 4'h0);
    chk("bp_out_c", 32'({tif.out_valid, o_pair()}), 32'h16);
    step();
    chk("bp_drained", 32'(tif.out_valid), 32'd0);
    chk("bp_count", 32'(tif.XFER_COUNT), 32'd3);

    // 5: 2-bit counter wrap over five transfers
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_w(1'b1, pat[i]);
      step();
      drive_w(1'b0, 4'h0);
      step();
      chk($sformatf("wrap_count_%0d", i), 32'(wif.XFER_COUNT), 32'((i + 1) % 4));
    end

    // 6: reset while full, then a single pair after release
    tif.out_ready = 1'b0;
    drive(1'b1, 4'h5);
    step();
    drive(1'b1, 4'hA);
    step();
    drive(1'b0, 4'h0);
    chk("full_before_rst", 32'(tif.in_ready), 32'd0);
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("full_rst_valid", 32'(tif.out_valid), 32'd0);
    chk("full_rst_ready", 32'(tif.in_ready), 32'd1);
    step();
    ASYNCRESETN = 1'b1;
    step();
    tif.out_ready = 1'b1;
    drive(1'b1, 4'h9);
    step();
    drive(1'b0, 4'h0);
    chk("post_rst_data", 32'({tif.out_valid, o_pair()}), 32'h19);
    step();
    chk("post_rst_count", 32'(tif.XFER_COUNT), 32'd1);
    chk("post_rst_empty", 32'(tif.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
